// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM
// state encoding and small op-classification helpers.
package lsu_pkg;

  localparam int WORD_BYTES = 4;

  localparam logic [2:0] LSU_LW  = 3'd0;
  localparam logic [2:0] LSU_LH  = 3'd1;
  localparam logic [2:0] LSU_LHU = 3'd2;
  localparam logic [2:0] LSU_LB  = 3'd3;
  localparam logic [2:0] LSU_LBU = 3'd4;
  localparam logic [2:0] LSU_SW  = 3'd5;
  localparam logic [2:0] LSU_SH  = 3'd6;
  localparam logic [2:0] LSU_SB  = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  function automatic logic is_store(input logic [2:0] op);
    return (op == LSU_SW) || (op == LSU_SH) || (op == LSU_SB);
  endfunction

  function automatic logic is_subword(input logic [2:0] op);
    return (op == LSU_SH) || (op == LSU_SB);
  endfunction

  // Word ops need lane 0; halfword ops need an even lane.
  function automatic logic misaligned(input logic [2:0] op,
                                      input logic [1:0] lo);
    logic m;
    m = 1'b0;
    if ((op == LSU_LW) || (op == LSU_SW))
      m = (lo != 2'b00);
    else if ((op == LSU_LH) || (op == LSU_LHU) || (op == LSU_SH))
      m = lo[0];
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads and lane
// merge for SB/SH read-modify-write.
// Ports: op_i, lane_i (addr[1:0]), rdata_i, wdata_i -> load_o, merge_o.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  bsh;
  logic [31:0] shr;
  logic [31:0] mask;

  // Halfword ops are even-aligned, so lane*8 also gives 16*addr[1].
  assign bsh = {lane_i, 3'b000};
  assign shr = rdata_i >> bsh;

  always_comb begin
    load_o = shr;
    unique case (op_i)
      LSU_LH:  load_o = {{16{shr[15]}}, shr[15:0]};
      LSU_LHU: load_o = {16'h0, shr[15:0]};
      LSU_LB:  load_o = {{24{shr[7]}}, shr[7:0]};
      LSU_LBU: load_o = {24'h0, shr[7:0]};
      default: load_o = shr;
    endcase
  end

  assign mask    = ((op_i == LSU_SH) ? 32'h0000_FFFF
                                     : 32'h0000_00FF) << bsh;
  assign merge_o = (rdata_i & ~mask) | ((wdata_i << bsh) & mask);

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, word-indexed
// memory, sub-word stores via read-modify-write.
// Ports: Clock, Reset_n (sync, active-low); Req_* request handshake;
// Resp_* response handshake; Address/Write_Data/MemWrite/MemRead/
// Read_Data to memory. Define LSU_STATS_EN for Stat_* counters.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int          MEM_DEPTH  = 256,
  parameter logic [31:0] RESET_DATA = 32'h0
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic [2:0]  Req_Op,
  input  logic [31:0] Req_Addr,
  input  logic [31:0] Req_Wdata,
  output logic        Resp_Valid,
  input  logic        Resp_Ready,
  output logic [31:0] Resp_Data,
  output logic        Resp_Error,
  output logic [31:0] Address,
  output logic [31:0] Write_Data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] Read_Data
`ifdef LSU_STATS_EN
  ,
  output logic [15:0] Stat_Loads,
  output logic [15:0] Stat_Stores,
  output logic [15:0] Stat_Errors
`endif
);

  logic [1:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] load_w, merge_w;
  logic        bad;

  assign bad = misaligned(Req_Op, Req_Addr[1:0]) ||
               ({2'b00, Req_Addr[31:2]} >= 32'(MEM_DEPTH));

  lsu_align u_align (
    .op_i    (op_q),
    .lane_i  (lane_q),
    .rdata_i (Read_Data),
    .wdata_i (wdata_q),
    .load_o  (load_w),
    .merge_o (merge_w)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Req_Valid) begin
          op_d    = Req_Op;
          lane_d  = Req_Addr[1:0];
          wdata_d = Req_Wdata;
          rdata_d = '0;
          err_d   = bad;
          if (bad) begin
            state_d = ST_RESP;
          end else begin
            addr_d = {2'b00, Req_Addr[31:2]};
            if (Req_Op == LSU_SW) begin
              wd_d    = Req_Wdata;
              state_d = ST_WRITE;
            end else begin
              state_d = ST_READ;
            end
          end
        end
      end
      ST_READ: begin
        if (is_subword(op_q)) begin
          wd_d    = merge_w;
          state_d = ST_WRITE;
        end else begin
          rdata_d = load_w;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (Resp_Ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= LSU_LW;
      lane_q  <= 2'b00;
      wdata_q <= '0;
      rdata_q <= RESET_DATA;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
    end
  end

  assign Req_Ready  = (state_q == ST_IDLE);
  assign Resp_Valid = (state_q == ST_RESP);
  assign Resp_Data  = rdata_q;
  assign Resp_Error = err_q;
  assign Address    = addr_q;
  assign Write_Data = wd_q;
  assign MemRead    = (state_q == ST_READ);
  assign MemWrite   = (state_q == ST_WRITE);

`ifdef LSU_STATS_EN
  logic        fire;
  logic [15:0] ld_q, st_q, er_q;

  assign fire = (state_q == ST_RESP) && Resp_Ready;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      ld_q <= '0;
      st_q <= '0;
      er_q <= '0;
    end else if (fire) begin
      if (err_q) begin
        if (er_q != 16'hFFFF) er_q <= er_q + 16'd1;
      end else if (is_store(op_q)) begin
        if (st_q != 16'hFFFF) st_q <= st_q + 16'd1;
      end else begin
        if (ld_q != 16'hFFFF) ld_q <= ld_q + 16'd1;
      end
    end
  end

  assign Stat_Loads  = ld_q;
  assign Stat_Stores = st_q;
  assign Stat_Errors = er_q;
`endif

endmodule
